// File: rtl/lcd_char_writer_if.sv
// Request/acknowledge bus between the UI screens and the character-LCD write engine.
// The master side raises req with a row/col/char; the engine answers with busy/done.
interface lcd_char_writer_if;
    logic       req;
    logic [1:0] row;
    logic [3:0] col;
    logic [7:0] char;
    logic       busy;
    logic       done;

    modport master (
        output req,
        output row,
        output col,
        output char,
        input  busy,
        input  done
    );

    modport slave (
        input  req,
        input  row,
        input  col,
        input  char,
        output busy,
        output done
    );
endinterface

// File: rtl/lcd_char_writer.sv
// HD44780 16x2 character writer (8-bit bus): power-up init, then single-character
// writes with a shadow DDRAM address so consecutive columns skip the set-address command.
module lcd_char_writer #(
    parameter int unsigned E_PULSE_CYC    = 25,
    parameter int unsigned CMD_WAIT_CYC   = 2500,
    parameter int unsigned CLEAR_WAIT_CYC = 100000,
    parameter int unsigned POWERUP_CYC    = 2000000
) (
    input  logic               clk,
    input  logic               rst_n,
    lcd_char_writer_if.slave   bus,
    output logic               lcd_rs,
    output logic               lcd_rw,
    output logic               lcd_e,
    output logic [7:0]         lcd_data
);

    localparam logic [2:0] S_POWERUP = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_IDLE    = 3'd2;
    localparam logic [2:0] S_ADDR    = 3'd3;
    localparam logic [2:0] S_DATA    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [1:0] P_SETUP = 2'd0;
    localparam logic [1:0] P_PULSE = 2'd1;
    localparam logic [1:0] P_HOLD  = 2'd2;

    localparam logic [23:0] E_LAST    = 24'(E_PULSE_CYC - 1);
    localparam logic [23:0] CMD_LAST  = 24'(CMD_WAIT_CYC - 1);
    localparam logic [23:0] CLR_LAST  = 24'(CLEAR_WAIT_CYC - 1);
    localparam logic [23:0] PWR_START = 24'(POWERUP_CYC);

    // Function set 8-bit/2-line, display on, clear, entry mode increment.
    localparam logic [31:0] INIT_SEQ = {8'h06, 8'h01, 8'h0C, 8'h38};
    localparam logic [1:0]  CLEAR_IDX = 2'd2;

    logic [7:0] init_cmd [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_init_cmd
            assign init_cmd[gi] = INIT_SEQ[gi*8 +: 8];
        end
    endgenerate

    logic [2:0]  state_reg,      state_next;
    logic [1:0]  phase_reg,      phase_next;
    logic [23:0] cnt_reg,        cnt_next;
    logic [1:0]  init_idx_reg,   init_idx_next;
    logic [6:0]  shadow_reg,     shadow_next;
    logic        addr_valid_reg, addr_valid_next;
    logic [6:0]  tgt_reg,        tgt_next;
    logic [7:0]  char_reg,       char_next;
    logic        rs_reg,         rs_next;
    logic [7:0]  data_reg,       data_next;
    logic        e_reg,          e_next;

    logic        in_bus_cycle;
    logic        cycle_end;
    logic [23:0] hold_last;
    logic [6:0]  req_tgt;
    logic        req_hit;
    logic [1:0]  init_idx_inc;
    logic        row_hi_unused;

    assign row_hi_unused = bus.row[1];

    assign in_bus_cycle = (state_reg == S_INIT) || (state_reg == S_ADDR) || (state_reg == S_DATA);
    assign cycle_end    = in_bus_cycle && (phase_reg == P_HOLD) && (cnt_reg == 24'd0);
    assign hold_last    = ((state_reg == S_INIT) && (init_idx_reg == CLEAR_IDX)) ? CLR_LAST : CMD_LAST;
    assign req_tgt      = bus.row[0] ? (7'h40 | {3'b000, bus.col}) : {3'b000, bus.col};
    assign req_hit      = addr_valid_reg && (req_tgt == shadow_reg);
    assign init_idx_inc = init_idx_reg + 2'd1;

    always_comb begin
        state_next      = state_reg;
        phase_next      = phase_reg;
        cnt_next        = cnt_reg;
        init_idx_next   = init_idx_reg;
        shadow_next     = shadow_reg;
        addr_valid_next = addr_valid_reg;
        tgt_next        = tgt_reg;
        char_next       = char_reg;
        rs_next         = rs_reg;
        data_next       = data_reg;
        e_next          = e_reg;

        // Shared bus-cycle sequencer: setup clock, enable pulse, then low hold.
        if (in_bus_cycle) begin
            case (phase_reg)
                P_SETUP: begin
                    phase_next = P_PULSE;
                    cnt_next   = E_LAST;
                    e_next     = 1'b1;
                end
                P_PULSE: begin
                    if (cnt_reg == 24'd0) begin
                        phase_next = P_HOLD;
                        cnt_next   = hold_last;
                        e_next     = 1'b0;
                    end else begin
                        cnt_next = cnt_reg - 24'd1;
                    end
                end
                default: begin
                    if (cnt_reg != 24'd0) begin
                        cnt_next = cnt_reg - 24'd1;
                    end
                end
            endcase
        end

        case (state_reg)
            S_POWERUP: begin
                if (cnt_reg == 24'd0) begin
                    state_next    = S_INIT;
                    phase_next    = P_SETUP;
                    init_idx_next = 2'd0;
                    rs_next       = 1'b0;
                    data_next     = init_cmd[0];
                end else begin
                    cnt_next = cnt_reg - 24'd1;
                end
            end
            S_INIT: begin
                if (cycle_end) begin
                    if (init_idx_reg == 2'd3) begin
                        state_next      = S_IDLE;
                        shadow_next     = 7'h00;
                        addr_valid_next = 1'b1;
                    end else begin
                        init_idx_next = init_idx_inc;
                        phase_next    = P_SETUP;
                        data_next     = init_cmd[init_idx_inc];
                    end
                end
            end
            S_IDLE: begin
                if (bus.req) begin
                    tgt_next   = req_tgt;
                    char_next  = bus.char;
                    phase_next = P_SETUP;
                    if (req_hit) begin
                        state_next = S_DATA;
                        rs_next    = 1'b1;
                        data_next  = bus.char;
                    end else begin
                        state_next = S_ADDR;
                        rs_next    = 1'b0;
                        data_next  = {1'b1, req_tgt};
                    end
                end
            end
            S_ADDR: begin
                if (cycle_end) begin
                    shadow_next = tgt_reg;
                    state_next  = S_DATA;
                    phase_next  = P_SETUP;
                    rs_next     = 1'b1;
                    data_next   = char_reg;
                end
            end
            S_DATA: begin
                // Panel auto-increments after a data write; no wrap to the next line.
                if (cycle_end) begin
                    shadow_next = shadow_reg + 7'd1;
                    state_next  = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next      = S_POWERUP;
                phase_next      = P_SETUP;
                cnt_next        = PWR_START;
                addr_valid_next = 1'b0;
                e_next          = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_POWERUP;
            phase_reg      <= P_SETUP;
            cnt_reg        <= PWR_START;
            init_idx_reg   <= 2'd0;
            shadow_reg     <= 7'h00;
            addr_valid_reg <= 1'b0;
            tgt_reg        <= 7'h00;
            char_reg       <= 8'h00;
            rs_reg         <= 1'b0;
            data_reg       <= 8'h00;
            e_reg          <= 1'b0;
        end else begin
            state_reg      <= state_next;
            phase_reg      <= phase_next;
            cnt_reg        <= cnt_next;
            init_idx_reg   <= init_idx_next;
            shadow_reg     <= shadow_next;
            addr_valid_reg <= addr_valid_next;
            tgt_reg        <= tgt_next;
            char_reg       <= char_next;
            rs_reg         <= rs_next;
            data_reg       <= data_next;
            e_reg          <= e_next;
        end
    end

    assign bus.busy = !((state_reg == S_IDLE) || (state_reg == S_DONE));
    assign bus.done = (state_reg == S_DONE);
    assign lcd_rw   = 1'b0;
    assign lcd_e    = e_reg;
    assign lcd_rs   = rs_reg;
    assign lcd_data = data_reg;

endmodule

// File: tb/tb_lcd_char_writer.sv
// Randomized bench for lcd_char_writer: a transaction-level model of the shadow DDRAM
// address predicts each write's bus pulses and done latency.
module tb_lcd_char_writer;

    localparam int E_P   = 2;
    localparam int C_W   = 4;
    localparam int CLR_W = 8;
    localparam int PWR   = 10;
    localparam int T_CMD = 1 + E_P + C_W;
    localparam int T_CLR = 1 + E_P + CLR_W;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data;

    always #5 clk = ~clk;

    lcd_char_writer_if bus ();

    lcd_char_writer #(
        .E_PULSE_CYC   (E_P),
        .CMD_WAIT_CYC  (C_W),
        .CLEAR_WAIT_CYC(CLR_W),
        .POWERUP_CYC   (PWR)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .lcd_rs  (lcd_rs),
        .lcd_rw  (lcd_rw),
        .lcd_e   (lcd_e),
        .lcd_data(lcd_data)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus monitor: records {rs,data} at each enable rise and checks bus stability around it.
    logic [8:0] got_q[$];
    int         done_cnt = 0;
    logic       prev_e = 1'b0;
    logic [8:0] prev_bus = 9'h0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (lcd_e && !prev_e) begin
                chk("setup_stable", {23'd0, lcd_rs, lcd_data}, {23'd0, prev_bus});
                got_q.push_back({lcd_rs, lcd_data});
            end
            if (!lcd_e && prev_e) begin
                chk("hold_stable", {23'd0, lcd_rs, lcd_data}, {23'd0, prev_bus});
            end
            if (bus.done) done_cnt++;
        end
        prev_e   = lcd_e;
        prev_bus = {lcd_rs, lcd_data};
    end

    // Reference model state: what the panel's address counter should hold.
    logic [6:0] m_shadow = 7'h00;
    bit         m_valid  = 1'b0;

    task automatic cmp_pulses(input string tag, input logic [8:0] exp_q[$]);
        chk({tag, "_npulse"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_pulse"}, {23'd0, got_q[i]}, {23'd0, exp_q[i]});
    endtask

    // Call just after releasing rst_n on a negedge.
    task automatic wait_init(input string tag);
        logic [8:0] exp_q[$];
        logic [7:0] seq [4];
        int n;
        seq = '{8'h38, 8'h0C, 8'h01, 8'h06};
        got_q.delete();
        done_cnt = 0;
        m_valid  = 1'b0;
        @(posedge clk);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.busy && n < 500);
        chk({tag, "_busy_fall"}, n, PWR + 3 * T_CMD + T_CLR);
        @(negedge clk);
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, seq[i]});
        cmp_pulses(tag, exp_q);
        chk({tag, "_no_done"}, done_cnt, 0);
        $display("init %s: busy fell after %0d clocks, %0d pulses", tag, n, got_q.size());
        m_shadow = 7'h00;
        m_valid  = 1'b1;
    endtask

    // Call on a negedge. hold_req keeps req high through the done clock.
    task automatic do_txn(input string tag, input logic [1:0] r, input logic [3:0] c,
                          input logic [7:0] ch, input bit hold_req);
        logic [8:0] exp_q[$];
        logic [6:0] tgt;
        bit         hit;
        int         lat, k, w;
        w = 0;
        while ((bus.busy || bus.done) && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) chk({tag, "_idle_timeout"}, w, 0);

        tgt = r[0] ? 7'(8'h40 + c) : {3'b000, c};
        hit = m_valid && (tgt == m_shadow);
        if (!hit) exp_q.push_back({2'b01, tgt});
        exp_q.push_back({1'b1, ch});
        lat = hit ? 1 + T_CMD : 1 + 2 * T_CMD;

        got_q.delete();
        bus.req  = 1'b1;
        bus.row  = r;
        bus.col  = c;
        bus.char = ch;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (!hold_req) begin
                bus.req  = 1'b0;
                bus.row  = 2'($urandom);
                bus.col  = 4'($urandom);
                bus.char = 8'($urandom);
            end
            if (k == 1) chk({tag, "_busy_rise"}, bus.busy, 1);
        end while (!bus.done && k < 100);
        chk({tag, "_latency"}, k, lat);
        chk({tag, "_busy_in_done"}, bus.busy, 0);
        cmp_pulses(tag, exp_q);
        $display("txn %s: row=%0d col=%0d char=0x%02h %s latency=%0d pulses=%0d",
                 tag, r, c, ch, hit ? "hit" : "miss", k, got_q.size());
        m_shadow = tgt + 7'd1;
        m_valid  = 1'b1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] r;
        logic [3:0] c;
        int w;
        bus.req  = 1'b0;
        bus.row  = 2'd0;
        bus.col  = 4'd0;
        bus.char = 8'd0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 1);
        chk("rst_done", bus.done, 0);
        chk("rst_e", lcd_e, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_rw", lcd_rw, 0);
        chk("rst_data", lcd_data, 8'h00);

        rst_n = 1'b1;
        wait_init("init");

        do_txn("hit0", 2'd0, 4'd0, 8'h41, 1'b0);
        do_txn("hit1", 2'd0, 4'd1, 8'h42, 1'b0);
        do_txn("miss", 2'd1, 4'd5, 8'h43, 1'b0);
        do_txn("col15", 2'd0, 4'd15, 8'h5A, 1'b0);
        do_txn("lineend", 2'd0, 4'd0, 8'h30, 1'b0);

        do_txn("held", 2'd2, 4'd7, 8'h61, 1'b1);
        do_txn("after_done", 2'd2, 4'd7, 8'h61, 1'b0);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                r = 2'($urandom);
                c = 4'($urandom);
            end else begin
                r = {1'($urandom), m_shadow[6]};
                c = m_shadow[3:0];
            end
            do_txn("rand", r, c, 8'($urandom), 1'b0);
        end

        // Reset while the enable strobe is high, then expect a full init replay.
        @(negedge clk);
        bus.req  = 1'b1;
        bus.row  = 2'd1;
        bus.col  = 4'd9;
        bus.char = 8'h77;
        @(negedge clk);
        bus.req = 1'b0;
        w = 0;
        while (!lcd_e && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) chk("midrst_e_timeout", w, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_e", lcd_e, 0);
        chk("midrst_busy", bus.busy, 1);
        chk("midrst_done", bus.done, 0);
        chk("midrst_rs", lcd_rs, 0);
        chk("midrst_data", lcd_data, 8'h00);
        $display("reset asserted mid-write");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_init("reinit");
        do_txn("post_reinit", 2'd0, 4'd0, 8'h21, 1'b0);
        do_txn("post_reinit2", 2'd1, 4'd0, 8'h22, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
